// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet buffer.
//   AXIS_DATA_W : default beat data width
//   AXIS_DEPTH  : default number of storage entries
//   axis_beat_t : one stored beat, {tlast, tdata}
package axis_pkg;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_DEPTH  = 16;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port register array used as packet storage.
//   clk   : write clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
// Contents are not reset; the pointers in the parent decide what is valid.
module axis_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet buffer.
// A packet is forwarded only once its TLAST beat is in storage. If storage
// fills without holding a complete packet, a force flag lets beats drain
// cut-through until that packet's TLAST reaches the output register.
//   ACLK / ARESET      : clock, synchronous active-high reset
//   DATA_in, TVALID_in, TLAST_in, TREADY_in     : upstream AXIS slave side
//   DATA_out, TVALID_out, TLAST_out, TREADY_out : downstream AXIS master side (registered)
//   level     : entries held in storage (output register excluded)
//   pkt_count : complete packets whose TLAST beat is still in storage
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = AXIS_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [DATA_W-1:0] DATA_in,
  input  logic              TVALID_in,
  input  logic              TLAST_in,
  output logic              TREADY_in,
  output logic [DATA_W-1:0] DATA_out,
  output logic              TVALID_out,
  output logic              TLAST_out,
  input  logic              TREADY_out,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] lvl;
  logic [CNT_W-1:0] pkt_q;
  logic             force_cut;
  logic [DATA_W:0]  rd_beat;
  logic             rd_last;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rel;
  logic             load;

  // Pointer MSB acts as a wrap bit, so the difference spans 0..DEPTH.
  assign lvl   = wr_ptr - rd_ptr;
  assign full  = (lvl == PTR_W'(DEPTH));
  assign empty = (lvl == '0);

  // Ready comes from registered full only, so a read in a full cycle frees
  // space for the following cycle, not the current one.
  assign TREADY_in = !full && !ARESET;
  assign wr_en     = TVALID_in && TREADY_in;

  assign rd_last = rd_beat[DATA_W];
  assign rel     = (pkt_q != '0) || force_cut;
  assign load    = (!TVALID_out || TREADY_out) && !empty && rel;

  assign level     = CNT_W'(lvl);
  assign pkt_count = pkt_q;

  axis_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (ACLK),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({TLAST_in, DATA_in}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_q      <= '0;
      force_cut  <= 1'b0;
      DATA_out   <= '0;
      TVALID_out <= 1'b0;
      TLAST_out  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({wr_en && TLAST_in, load && rd_last})
        2'b10:   pkt_q <= pkt_q + CNT_W'(1);
        2'b01:   pkt_q <= pkt_q - CNT_W'(1);
        default: pkt_q <= pkt_q;
      endcase

      // A stored TLAST implies pkt_q > 0, so set and clear never coincide.
      if (load && rd_last)
        force_cut <= 1'b0;
      else if (full && (pkt_q == '0))
        force_cut <= 1'b1;

      if (load) begin
        DATA_out   <= rd_beat[DATA_W-1:0];
        TLAST_out  <= rd_last;
        TVALID_out <= 1'b1;
      end else if (TREADY_out) begin
        TVALID_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
module tb_axis_packet_fifo;
  import axis_pkg::*;

  logic       ACLK;
  logic       ARESET;
  logic [7:0] DATA_in;
  logic       TVALID_in;
  logic       TLAST_in;
  logic       TREADY_in;
  logic [7:0] DATA_out;
  logic       TVALID_out;
  logic       TLAST_out;
  logic       TREADY_out;
  logic [4:0] level;
  logic [4:0] pkt_count;

  axis_packet_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .DATA_in    (DATA_in),
    .TVALID_in  (TVALID_in),
    .TLAST_in   (TLAST_in),
    .TREADY_in  (TREADY_in),
    .DATA_out   (DATA_out),
    .TVALID_out (TVALID_out),
    .TLAST_out  (TLAST_out),
    .TREADY_out (TREADY_out),
    .level      (level),
    .pkt_count  (pkt_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  axis_beat_t sb[$];

  always @(posedge ACLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    bit ok;
    axis_beat_t b;
    ok = 1'b0;
    DATA_in   = d;
    TLAST_in  = l;
    TVALID_in = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (TREADY_in) begin
        b.tlast = l;
        b.tdata = d;
        sb.push_back(b);
        ok = 1'b1;
      end
      tick();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
    chk("drain_queue_empty", sb.size(), 0);
    chk("drain_tvalid_low", TVALID_out, 0);
  endtask

  // Monitor: compare every handshaked output beat and check AXIS stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge ACLK) begin
    axis_beat_t e;
    if (ARESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", TVALID_out, 1);
        chk("stall_data_held", DATA_out, prev_data);
        chk("stall_last_held", TLAST_out, prev_last);
      end
      if (TVALID_out && TREADY_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", DATA_out, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("beat_data", DATA_out, e.tdata);
          chk("beat_last", TLAST_out, e.tlast);
        end
      end
      prev_stall = TVALID_out && !TREADY_out;
      prev_data  = DATA_out;
      prev_last  = TLAST_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    ARESET = 1'b1; DATA_in = '0; TVALID_in = 1'b0; TLAST_in = 1'b0; TREADY_out = 1'b0;
    tick(); tick(); tick();
    chk("rst_tready_in", TREADY_in, 0);
    chk("rst_tvalid_out", TVALID_out, 0);
    chk("rst_data_out", DATA_out, 0);
    chk("rst_level", level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    ARESET = 1'b0;
    #1;
    chk("rst_release_tready_in", TREADY_in, 1);

    // 1: basic 3-beat packet, store-and-forward latency
    TREADY_out = 1'b1;
    send_beat(8'h11, 1'b0);
    chk("t1_no_early_valid_a", TVALID_out, 0);
    send_beat(8'h22, 1'b0);
    chk("t1_no_early_valid_b", TVALID_out, 0);
    send_beat(8'h33, 1'b1);
    TVALID_in = 1'b0;
    chk("t1_no_valid_at_tlast", TVALID_out, 0);
    chk("t1_pkt_count_1", pkt_count, 1);
    tick();
    chk("t1_head_valid", TVALID_out, 1);
    chk("t1_head_data", DATA_out, 8'h11);
    tick();
    chk("t1_second_data", DATA_out, 8'h22);
    tick();
    chk("t1_third_last", TLAST_out, 1);
    chk("t1_pkt_count_0", pkt_count, 0);
    tick();
    chk("t1_done_valid", TVALID_out, 0);
    chk("t1_done_level", level, 0);

    // 2: same packet, downstream stalled for 4 cycles
    TREADY_out = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    TVALID_in = 1'b0;
    tick();
    chk("t2_head_valid", TVALID_out, 1);
    chk("t2_head_data", DATA_out, 8'h11);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_hold_data", DATA_out, 8'h11);
    end
    chk("t2_level_stalled", level, 2);
    TREADY_out = 1'b1;
    drain();

    // 3: 20-beat packet overruns storage, force cut-through
    TREADY_out = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(8'h40 + 8'(i), (i == 19));
        TVALID_in = 1'b0;
      end
      begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
          if (level == 5'd16) found = 1'b1;
          else tick();
        end
        chk("t3_reached_full", found, 1);
        chk("t3_full_no_valid", TVALID_out, 0);
        chk("t3_full_pkt_0", pkt_count, 0);
        chk("t3_force_clear_before", dut.force_cut, 0);
        TREADY_out = 1'b1;
        tick();
        chk("t3_force_set", dut.force_cut, 1);
        chk("t3_valid_not_yet", TVALID_out, 0);
        tick();
        chk("t3_beat0_valid", TVALID_out, 1);
        chk("t3_beat0_data", DATA_out, 8'h40);
      end
    join
    drain();
    chk("t3_force_cleared", dut.force_cut, 0);
    chk("t3_level_0", level, 0);
    chk("t3_pkt_0", pkt_count, 0);

    // 4: two back-to-back 2-beat packets
    TREADY_out = 1'b0;
    send_beat(8'hA0, 1'b0);
    send_beat(8'hA1, 1'b1);
    send_beat(8'hB0, 1'b0);
    send_beat(8'hB1, 1'b1);
    TVALID_in = 1'b0;
    chk("t4_pkt_count_2", pkt_count, 2);
    chk("t4_level_3", level, 3);
    TREADY_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_contiguous_valid", TVALID_out, 1);
      tick();
    end
    chk("t4_done_valid", TVALID_out, 0);
    chk("t4_done_pkt", pkt_count, 0);

    // 5: fill with 1-beat packets, then stream at full rate
    TREADY_out = 1'b0;
    for (int i = 0; i < 17; i++) send_beat(8'h60 + 8'(i), 1'b1);
    chk("t5_level_full", level, 16);
    chk("t5_tready_in_low", TREADY_in, 0);
    chk("t5_pkt_count_16", pkt_count, 16);
    TREADY_out = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      send_beat(8'h90 + 8'(i), 1'b1);
      chk("t5_level_15_16", (level == 5'd15 || level == 5'd16), 1);
    end
    chk("t5_throughput_cycles", cyc - c0, 11);
    TVALID_in = 1'b0;
    drain();

    // 6: reset mid-packet
    TREADY_out = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(8'hD0 + 8'(i), 1'b0);
    TVALID_in = 1'b0;
    chk("t6_level_5", level, 5);
    ARESET = 1'b1;
    #1;
    chk("t6_tready_in_in_reset", TREADY_in, 0);
    tick();
    chk("t6_level_0", level, 0);
    chk("t6_pkt_0", pkt_count, 0);
    chk("t6_tvalid_0", TVALID_out, 0);
    chk("t6_tready_in_still_reset", TREADY_in, 0);
    ARESET = 1'b0;
    sb.delete();
    #1;
    chk("t6_tready_in_after", TREADY_in, 1);
    TREADY_out = 1'b1;
    send_beat(8'hC0, 1'b0);
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b1);
    TVALID_in = 1'b0;
    drain();
    chk("t6_final_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Store-and-forward AXI-Stream packet buffer; sits directly downstream of the 2:1 AXIS mux and absorbs its output stream.
- Forwards a packet only once its TLAST beat is stored, so downstream sees gap-free packets.
- Forced cut-through prevents deadlock when one packet exceeds buffer depth.
- Provides occupancy and stored-packet status to the control logic.

Parameters:
- DATA_W, 8, width of DATA_in / DATA_out.
- DEPTH, 16, storage entries; power of 2, at least 2; excludes the output register.
- CNT_W, $clog2(DEPTH)+1, width of the level and pkt_count outputs.

Ports:
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- DATA_in  in  DATA_W  upstream data (the mux output).
- TVALID_in  in  1  upstream beat valid.
- TLAST_in  in  1  upstream last beat of packet.
- TREADY_in  out  1  beat accepted when TVALID_in and TREADY_in are both high.
- DATA_out  out  DATA_W  downstream data, registered.
- TVALID_out  out  1  downstream valid, registered.
- TLAST_out  out  1  downstream last, registered.
- TREADY_out  in  1  downstream ready.
- level  out  CNT_W  entries held in storage, 0..DEPTH.
- pkt_count  out  CNT_W  complete packets (TLAST stored) still in storage.

Interface decision: one clock, ACLK; reset ARESET is synchronous and active-high.

Behaviour:
- Reset (ARESET high at an edge):
  - Pointers, level, pkt_count and force flag go to 0.
  - DATA_out, TVALID_out and TLAST_out go to 0.
  - TREADY_in is 0 while ARESET is high.
  - Reset mid-packet discards all stored and partial data; no partial packet survives.
- Storage: DEPTH x {TLAST, DATA}.
  - Read/write pointers are log2(DEPTH)+1 bits and wrap naturally; the MSB distinguishes full from empty.
  - full = (level == DEPTH).
- Write: TREADY_in = !full && !ARESET, decoded combinationally from registered state.
  - An accepted beat is stored at that edge; throughput is 1 beat/cycle while not full.
- pkt_count: +1 when a TLAST beat is written, -1 when a TLAST beat moves from storage to the output register. Both in the same cycle leaves it unchanged.
- release = (pkt_count > 0) || force.
- Output register is loaded at an edge when all of the following hold:
  - the register is empty, or being consumed (TVALID_out && TREADY_out);
  - storage is not empty;
  - release is true.
- If the register is consumed and no load occurs, TVALID_out goes to 0.
- AXIS rule: while TVALID_out && !TREADY_out, DATA_out, TLAST_out and TVALID_out hold stable.
- Latency: a TLAST beat accepted at edge N gives pkt_count updated after N. The packet head loads at edge N+1, so TVALID_out is high after N+1. Subsequent beats stream at 1/cycle with no bubbles while TREADY_out is high.
- Force (deadlock escape):
  - force sets at an edge where full && pkt_count == 0.
  - It clears at the edge where a TLAST beat is loaded into the output register.
  - While force is set, beats drain cut-through.
- Simultaneous write and read: level is unchanged.
- When full, a same-cycle read does not admit a write, because TREADY_in depends on registered full. Space becomes available the next cycle.
- Beats with TLAST are never dropped or reordered; beats are never duplicated.
- A packet of exactly DEPTH beats is released normally, since its TLAST is stored before full triggers force.

Decomposition:
- Shared package axis_pkg:
  - AXIS_DATA_W = 8;
  - a packed beat typedef {tlast, tdata};
  - the DEPTH default.
- Sub-module axis_fifo_mem:
  - simple dual-port register array;
  - synchronous write (we, waddr, wdata);
  - combinational read (raddr, rdata);
  - no reset on storage contents.
- Pointers, counters, force flag and output register stay in axis_packet_fifo.

Test Plan:
- 3-beat packet 0x11, 0x22, 0x33 (TLAST on 0x33) with TREADY_out=1 -> TVALID_out stays 0 until the edge after 0x33 is accepted, then 0x11, 0x22, 0x33 on 3 consecutive cycles; TLAST_out only on 0x33; pkt_count pulses 1 then 0.
- Same packet with TREADY_out=0 for 4 cycles after first valid -> DATA_out holds 0x11 stable; on release, no beat is lost or duplicated.
- DEPTH=16, 20-beat packet, TREADY_out=0 until level=16, then 1 -> force sets when full; beat 0 emerges 1 cycle later; all 20 beats arrive in order with TLAST on beat 19; force clears.
- Two back-to-back 2-beat packets (0xA0, 0xA1 | 0xB0, 0xB1), TREADY_out=1 -> pkt_count reaches 2; output is 4 contiguous beats with TLAST on 0xA1 and 0xB1.
- Fill to level=16 with complete 1-beat packets, then hold TVALID_in=1 and TREADY_out=1 -> TREADY_in=0 at full; steady 1 beat/cycle in and out afterwards with level oscillating at 15/16.
- ARESET pulsed for 1 cycle mid-packet after 5 beats stored -> next cycle: level=0, pkt_count=0, TVALID_out=0; TREADY_in=0 during reset and 1 after; a fresh packet then passes correctly.
